axi4_read_burst_engine: RTL and testbench

AXI4_READ_BURST_ENGINE -- requirements
Module: axi4_read_burst_engine

---
 rtl/axi4_read_burst_engine.sv | 134 +++++++++++++
 tb/tb_axi4_read_burst_engine.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_read_burst_engine.sv
// axi4_read_burst_engine: splits a read command into 4 KB-safe AXI4 INCR bursts and streams the returned beats
module axi4_read_burst_engine #(
    parameter int ADDR_W          = 64,
    parameter int DATA_W          = 512,
    parameter int ID_W            = 1,
    parameter int MAX_BURST       = 64,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = 32,
    parameter int SWAP_GRAN       = 1
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [CNT_W-1:0]  cmd_beats,
    input  logic              cmd_swap,
    output logic              m_arvalid,
    input  logic              m_arready,
    output logic [ADDR_W-1:0] m_araddr,
    output logic [7:0]        m_arlen,
    output logic [2:0]        m_arsize,
    output logic [1:0]        m_arburst,
    output logic [ID_W-1:0]   m_arid,
    output logic [3:0]        m_arcache,
    input  logic              m_rvalid,
    output logic              m_rready,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_rlast,
    input  logic [1:0]        m_rresp,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [DATA_W-1:0] dout_data,
    output logic              dout_last,
    output logic              done,
    output logic              error
);
    localparam int BYTES = DATA_W / 8;
    localparam int SZ    = $clog2(BYTES);
    localparam int OW    = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW    = (CNT_W > 13) ? CNT_W : 13;
    localparam int UB    = SWAP_GRAN * 8;
    localparam int NU    = DATA_W / UB;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  remaining, beats, rcv;
    logic              swap;
    logic [OW-1:0]     outstanding;
    logic [12:0]       to_4k, cap;
    logic [CW-1:0]     burst;
    logic [DATA_W-1:0] swapped;
    logic              cmd_hs, ar_hs, r_hs, rl_hs, all_rcv;

    // Burst length is the tightest of: beats left, max burst, beats before the next 4 KB page.
    assign to_4k   = (13'h1000 - {1'b0, addr[11:0]}) >> SZ;
    assign cap     = (to_4k < 13'(MAX_BURST)) ? to_4k : 13'(MAX_BURST);
    assign burst   = (CW'(remaining) < CW'(cap)) ? CW'(remaining) : CW'(cap);

    assign cmd_hs  = cmd_valid & cmd_ready;
    assign ar_hs   = m_arvalid & m_arready;
    assign r_hs    = m_rvalid & m_rready & (state != IDLE);
    assign rl_hs   = r_hs & m_rlast;
    assign all_rcv = (rcv == beats);

    assign m_araddr  = addr;
    assign m_arlen   = (state == ISSUE) ? 8'(burst - CW'(1)) : 8'd0;
    assign m_arsize  = 3'(SZ);
    assign m_arburst = 2'b01;
    assign m_arid    = '0;
    assign m_arcache = 4'b0011;

    for (genvar i = 0; i < NU; i++) begin : g_swap
        assign swapped[i*UB +: UB] = m_rdata[(NU-1-i)*UB +: UB];
    end

    assign m_rready   = dout_ready;
    assign dout_valid = m_rvalid;
    assign dout_data  = swap ? swapped : m_rdata;
    assign dout_last  = m_rvalid & (state != IDLE) & (rcv == beats - CNT_W'(1));

    // State register.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) state <= IDLE;
        else           state <= state_nxt;
    end

    // Next state plus the handshake outputs that depend only on state.
    always_comb begin
        state_nxt = state;
        cmd_ready = (state == IDLE);
        m_arvalid = (state == ISSUE) && (outstanding < OW'(MAX_OUTSTANDING));
        case (state)
            IDLE:    state_nxt = (cmd_hs && cmd_beats != '0) ? ISSUE : IDLE;
            ISSUE:   state_nxt = (ar_hs && CW'(remaining) == burst) ? DRAIN : ISSUE;
            DRAIN:   state_nxt = (outstanding == '0 && all_rcv) ? IDLE : DRAIN;
            default: state_nxt = IDLE;
        endcase
    end

    // Command latch, address/beat bookkeeping, outstanding tracking, done and sticky error.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            addr        <= '0;
            remaining   <= '0;
            beats       <= '0;
            rcv         <= '0;
            swap        <= 1'b0;
            outstanding <= '0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            done <= (state == DRAIN) && (outstanding == '0) && all_rcv;
            if (cmd_hs) begin
                addr      <= cmd_addr & ~ADDR_W'(BYTES - 1);
                remaining <= cmd_beats;
                beats     <= cmd_beats;
                swap      <= cmd_swap;
                rcv       <= '0;
                error     <= 1'b0;
                done      <= (cmd_beats == '0);
            end
            if (ar_hs) begin
                addr      <= addr + (ADDR_W'(burst) << SZ);
                remaining <= remaining - CNT_W'(burst);
            end
            outstanding <= outstanding + OW'(ar_hs) - OW'(rl_hs);
            if (r_hs) rcv <= rcv + CNT_W'(1);
            if (m_rvalid && m_rready && m_rresp != 2'b00) error <= 1'b1;
        end
    end
endmodule

// File: tb/tb_axi4_read_burst_engine.sv
// tb_axi4_read_burst_engine: table-driven and randomized checks against a burst-splitting reference model
module tb_axi4_read_burst_engine;
    localparam int DW = 512;

    logic          ap_clk = 1'b0;
    logic          ap_rst_n = 1'b0;
    logic          cmd_valid, cmd_ready, cmd_swap;
    logic [63:0]   cmd_addr;
    logic [31:0]   cmd_beats;
    logic          m_arvalid, m_arready;
    logic [63:0]   m_araddr;
    logic [7:0]    m_arlen;
    logic [2:0]    m_arsize;
    logic [1:0]    m_arburst;
    logic [0:0]    m_arid;
    logic [3:0]    m_arcache;
    logic          m_rvalid, m_rready, m_rlast;
    logic [DW-1:0] m_rdata;
    logic [1:0]    m_rresp;
    logic          dout_valid, dout_ready, dout_last, done, error;
    logic [DW-1:0] dout_data;

    always #5 ap_clk = ~ap_clk;

    axi4_read_burst_engine dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_beats(cmd_beats), .cmd_swap(cmd_swap),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
        .m_arid(m_arid), .m_arcache(m_arcache),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
        .m_rlast(m_rlast), .m_rresp(m_rresp),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
        .dout_last(dout_last), .done(done), .error(error)
    );

    typedef struct {
        logic [63:0] addr;
        int          beats;
        bit          swap;
        bit          rnd;
        int          n_ar;
        int          len0;
        logic [63:0] addr0;
    } vec_t;

    int          pass_n = 0, total_n = 0;
    bit          r_en = 1, ar_rnd = 0, rdy_rnd = 0, gap_rnd = 0, aa_mode = 0;
    int          err_beat = -1;
    int          pend[$];
    int          r_idx = 0, r_glob = 0;
    int          ar_cnt = 0, beats_cnt = 0, last_cnt = 0, rl_cnt = 0, done_cnt = 0, outs = 0, ar5_rl = -1;
    bit          exp_err = 0, swap_l = 0, acc = 0, held = 0;
    int          beats_l = 0;
    logic [71:0] held_v;
    logic [63:0] exp_addr[64];
    int          exp_len[64];
    int          n_exp = 0;
    logic [63:0] first_addr;
    int          first_len;
    vec_t        tbl[6];

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [DW-1:0] swap_ref(input logic [DW-1:0] d);
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 8; i++) r[8*i +: 8] = d[DW-8-8*i +: 8];
        return r;
    endfunction

    // One clock: observe handshakes at the falling edge, then drive new inputs just after the rising edge.
    task automatic tick;
        bit r_fire;
        @(negedge ap_clk);
        acc = cmd_valid && cmd_ready;
        if (acc) begin
            ar_cnt = 0; beats_cnt = 0; last_cnt = 0; rl_cnt = 0; done_cnt = 0;
            exp_err = 0; r_glob = 0; ar5_rl = -1;
            swap_l = cmd_swap; beats_l = int'(cmd_beats);
        end
        chk("r_passthru", {dout_valid, m_rready}, {m_rvalid, dout_ready});
        if (held) chk("ar_hold", {m_arvalid, m_araddr, m_arlen}, {1'b1, held_v});
        if (m_arvalid) begin
            chk("ar_outstanding", outs < 4, 1'b1);
            if (m_arready) begin
                if (ar_cnt < n_exp) chk("ar_addr_len", {m_araddr, m_arlen}, {exp_addr[ar_cnt], 8'(exp_len[ar_cnt])});
                else chk("ar_extra", ar_cnt, n_exp);
                if (ar_cnt == 0) begin first_addr = m_araddr; first_len = int'(m_arlen); end
                if (ar_cnt == 4) ar5_rl = rl_cnt;
                pend.push_back(int'(m_arlen));
                outs++;
                ar_cnt++;
            end
        end
        held = m_arvalid && !m_arready;
        held_v = {m_araddr, m_arlen};
        r_fire = m_rvalid && m_rready;
        if (r_fire) begin
            chk("dout_data", dout_data, swap_l ? swap_ref(m_rdata) : m_rdata);
            if (aa_mode && beats_cnt == 0) chk("swap_byte63", dout_data[DW-1 -: 8], 8'hAA);
            chk("dout_last", dout_last, beats_cnt == beats_l - 1);
            last_cnt += int'(dout_last);
            if (m_rresp != 2'b00) exp_err = 1;
            if (m_rlast) begin outs--; rl_cnt++; end
            beats_cnt++;
        end
        if (done) done_cnt++;
        @(posedge ap_clk);
        #2;
        if (acc) cmd_valid = 1'b0;
        m_arready = ar_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        dout_ready = rdy_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (r_fire) begin
            m_rvalid = 1'b0;
            if (m_rlast) begin pend.delete(0); r_idx = 0; end
            else r_idx++;
            r_glob++;
        end
        if (!m_rvalid && r_en && pend.size() > 0 && (!gap_rnd || $urandom_range(0, 3) != 0)) begin
            for (int k = 0; k < DW / 32; k++) m_rdata[32*k +: 32] = $urandom;
            if (aa_mode) m_rdata[7:0] = 8'hAA;
            m_rlast = (r_idx == pend[0]);
            m_rresp = (r_glob == err_beat) ? 2'b10 : 2'b00;
            m_rvalid = 1'b1;
        end
    endtask

    // Reference burst list: peel off min(remaining, 64, beats to the 4 KB page end) repeatedly.
    task automatic start_cmd(input logic [63:0] a, input int b, input bit s);
        logic [63:0] x;
        int rem, n, t;
        x = a & ~64'h3F;
        rem = b;
        n_exp = 0;
        while (rem > 0) begin
            n = (4096 - int'(x[11:0])) / 64;
            if (n > 64) n = 64;
            if (rem < n) n = rem;
            exp_addr[n_exp] = x;
            exp_len[n_exp] = n - 1;
            n_exp++;
            x += 64'(n * 64);
            rem -= n;
        end
        cmd_addr = a; cmd_beats = 32'(b); cmd_swap = s; cmd_valid = 1'b1;
        acc = 0;
        t = 0;
        while (!acc && t < 100) begin tick; t++; end
        chk("cmd_accept", acc, 1'b1);
    endtask

    task automatic finish_cmd(input int b);
        int t;
        t = 0;
        while (done_cnt == 0 && t < 4000) begin tick; t++; end
        repeat (3) tick;
        chk("done_once", done_cnt, 1);
        chk("beat_count", beats_cnt, b);
        chk("ar_count", ar_cnt, n_exp);
        chk("last_count", last_cnt, b > 0);
        chk("error_flag", error, exp_err);
        chk("idle_ready", cmd_ready, 1'b1);
    endtask

    task automatic run_cmd(input logic [63:0] a, input int b, input bit s);
        start_cmd(a, b, s);
        finish_cmd(b);
    endtask

    initial begin
        int t;
        tbl[0] = '{64'h1000, 16,  1'b0, 1'b0, 1, 15, 64'h1000};
        tbl[1] = '{64'h0F80, 8,   1'b0, 1'b0, 2, 1,  64'h0F80};
        tbl[2] = '{64'h0000, 0,   1'b0, 1'b0, 0, 0,  64'h0000};
        tbl[3] = '{64'h0FC0, 130, 1'b1, 1'b1, 4, 0,  64'h0FC0};
        tbl[4] = '{64'h123F, 5,   1'b1, 1'b0, 1, 4,  64'h1200};
        tbl[5] = '{64'h2000, 300, 1'b0, 1'b1, 5, 63, 64'h2000};
        cmd_valid = 0; cmd_addr = 0; cmd_beats = 0; cmd_swap = 0;
        m_arready = 1; m_rvalid = 0; m_rdata = '0; m_rlast = 0; m_rresp = 0; dout_ready = 1;
        #1;
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_ar", {m_arvalid, m_araddr, m_arlen}, 73'd0);
        chk("rst_done_err", {done, error}, 2'b00);
        chk("ar_const", {m_arsize, m_arburst, m_arid, m_arcache}, {3'd6, 2'b01, 1'b0, 4'b0011});
        repeat (3) @(posedge ap_clk);
        #2 ap_rst_n = 1'b1;

        foreach (tbl[i]) begin
            ar_rnd = tbl[i].rnd; rdy_rnd = tbl[i].rnd; gap_rnd = tbl[i].rnd;
            run_cmd(tbl[i].addr, tbl[i].beats, tbl[i].swap);
            chk("tbl_ar_count", ar_cnt, tbl[i].n_ar);
            if (tbl[i].n_ar > 0) chk("tbl_first_ar", {first_addr, 8'(first_len)}, {tbl[i].addr0, 8'(tbl[i].len0)});
        end
        ar_rnd = 0; rdy_rnd = 0; gap_rnd = 0;

        aa_mode = 1; rdy_rnd = 1;
        run_cmd(64'h5000, 20, 1'b1);
        aa_mode = 0; rdy_rnd = 0;

        err_beat = 3;
        run_cmd(64'h6000, 16, 1'b0);
        chk("error_sticky", error, 1'b1);
        err_beat = -1;
        start_cmd(64'h7000, 4, 1'b0);
        chk("error_clear", error, 1'b0);
        finish_cmd(4);

        r_en = 0;
        start_cmd(64'h0, 300, 1'b0);
        repeat (20) tick;
        chk("ar_before_r", ar_cnt, 4);
        chk("ar_stalled", m_arvalid, 1'b0);
        r_en = 1;
        finish_cmd(300);
        chk("fifth_after_rlast", ar5_rl >= 1, 1'b1);

        r_en = 0;
        start_cmd(64'h8000, 300, 1'b0);
        t = 0;
        while (ar_cnt < 2 && t < 100) begin tick; t++; end
        chk("two_ars_before_rst", ar_cnt, 2);
        ap_rst_n = 1'b0;
        #1;
        chk("midrst_cmd_ready", cmd_ready, 1'b1);
        chk("midrst_ar", {m_arvalid, m_araddr, m_arlen}, 73'd0);
        chk("midrst_done_err", {done, error}, 2'b00);
        pend.delete(); m_rvalid = 0; r_idx = 0; outs = 0; held = 0; done_cnt = 0;
        repeat (2) tick;
        ap_rst_n = 1'b1;
        repeat (10) tick;
        chk("no_done_after_rst", done_cnt, 0);
        r_en = 1;
        run_cmd(64'h9000, 40, 1'b1);

        ar_rnd = 1; rdy_rnd = 1; gap_rnd = 1;
        for (int i = 0; i < 12; i++)
            run_cmd({32'h0, $urandom}, $urandom_range(1, 200), 1'($urandom_range(0, 1)));

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
